// File: rtl/segment_ex_mem_hs.sv
// EX->MEM pipeline segment with valid/ready flow control, flush and optional skid entry.
// State updates on the falling clock edge; the MEM side always sees the main entry.
module segment_ex_mem_hs #(
  parameter int DATA_W = 192,
  parameter int RR_W   = 4,
  parameter int CTRL_W = 6,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mux1_in,
  input  logic [RR_W-1:0]   rr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] mux1_out,
  output logic [RR_W-1:0]   rr_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_alu_q,  main_alu_d;
  logic [DATA_W-1:0] main_mux1_q, main_mux1_d;
  logic [RR_W-1:0]   main_rr_q,   main_rr_d;

  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_alu_q,  skid_alu_d;
  logic [DATA_W-1:0] skid_mux1_q, skid_mux1_d;
  logic [RR_W-1:0]   skid_rr_q,   skid_rr_d;

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic accept;
  logic consume;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // State register: every entry is lost on reset.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_alu_q  <= '0;
      main_mux1_q <= '0;
      main_rr_q   <= '0;
      skid_ctrl_q <= '0;
      skid_alu_q  <= '0;
      skid_mux1_q <= '0;
      skid_rr_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_alu_q  <= main_alu_d;
      main_mux1_q <= main_mux1_d;
      main_rr_q   <= main_rr_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_alu_q  <= skid_alu_d;
      skid_mux1_q <= skid_mux1_d;
      skid_rr_q   <= skid_rr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state: flush overrides any handshake in the same edge.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (consume && !accept) state_d = ST_EMPTY;
          else if (accept && !consume && (SKID != 0)) state_d = ST_TWO;
        end
        ST_TWO:   if (consume) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry data: stale payload is kept on flush; only the valid state is cleared.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_alu_d  = main_alu_q;
    main_mux1_d = main_mux1_q;
    main_rr_d   = main_rr_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_alu_d  = skid_alu_q;
    skid_mux1_d = skid_mux1_q;
    skid_rr_d   = skid_rr_q;
    if (!flush) begin
      if ((state_q == ST_EMPTY && accept) || (state_q == ST_ONE && accept && consume)) begin
        main_ctrl_d = ctrl_in;
        main_alu_d  = alu_in;
        main_mux1_d = mux1_in;
        main_rr_d   = rr_in;
      end else if (state_q == ST_ONE && accept) begin
        skid_ctrl_d = ctrl_in;
        skid_alu_d  = alu_in;
        skid_mux1_d = mux1_in;
        skid_rr_d   = rr_in;
      end else if (state_q == ST_TWO && consume) begin
        main_ctrl_d = skid_ctrl_q;
        main_alu_d  = skid_alu_q;
        main_mux1_d = skid_mux1_q;
        main_rr_d   = skid_rr_q;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  // Outputs: with the skid entry, in_ready depends only on registered state.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    if (SKID != 0) in_ready = (state_q != ST_TWO);
    else           in_ready = (state_q == ST_EMPTY) | out_ready;
    ctrl_out  = out_valid ? main_ctrl_q : '0;
    alu_out   = main_alu_q;
    mux1_out  = main_mux1_q;
    rr_out    = main_rr_q;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_segment_ex_mem_hs.sv
// Directed bench for segment_ex_mem_hs: skid instance (CNT_W=4) plus a single-entry instance.
module tb_segment_ex_mem_hs;
  localparam int W = 192;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [5:0]   ctrl_in;
  logic [W-1:0] alu_in, mux1_in;
  logic [3:0]   rr_in;

  logic         in_ready, out_valid;
  logic [5:0]   ctrl_out;
  logic [W-1:0] alu_out, mux1_out;
  logic [3:0]   rr_out;
  logic [3:0]   stall_cnt;

  logic         in_ready0, out_valid0;
  logic [5:0]   ctrl_out0;
  logic [W-1:0] alu_out0, mux1_out0;
  logic [3:0]   rr_out0;
  logic [15:0]  stall_cnt0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  segment_ex_mem_hs #(.DATA_W(W), .RR_W(4), .CTRL_W(6), .SKID(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .alu_in(alu_in), .mux1_in(mux1_in), .rr_in(rr_in),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out), .alu_out(alu_out),
    .mux1_out(mux1_out), .rr_out(rr_out), .stall_cnt(stall_cnt)
  );

  segment_ex_mem_hs #(.DATA_W(W), .RR_W(4), .CTRL_W(6), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .ctrl_in(ctrl_in), .alu_in(alu_in), .mux1_in(mux1_in), .rr_in(rr_in),
    .out_valid(out_valid0), .out_ready(out_ready), .ctrl_out(ctrl_out0), .alu_out(alu_out0),
    .mux1_out(mux1_out0), .rr_out(rr_out0), .stall_cnt(stall_cnt0)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [5:0] c, input logic [W-1:0] a,
                     input logic [3:0] r, input logic ordy);
    in_valid  = v;
    ctrl_in   = c;
    alu_in    = a;
    mux1_in   = ~a;
    rr_in     = r;
    out_ready = ordy;
  endtask

  // One falling (active) edge, then settle just after the following rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drv(1'b0, 6'h00, '0, 4'h0, 1'b0);
    #2;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_ctrl_out",  W'(ctrl_out),  W'(0));
    chk("rst_alu_out",   alu_out,       W'(0));
    chk("rst_mux1_out",  mux1_out,      W'(0));
    chk("rst_rr_out",    W'(rr_out),    W'(0));
    chk("rst_stall_cnt", W'(stall_cnt), W'(0));
    chk("rst_in_ready0", W'(in_ready0), W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming at full rate
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, 6'(i), W'(i), 4'(i), 1'b1);
      step();
      chk("t1_alu",      alu_out,        W'(i));
      chk("t1_mux1",     mux1_out,       ~W'(i));
      chk("t1_ctrl",     W'(ctrl_out),   W'(i));
      chk("t1_rr",       W'(rr_out),     W'(i));
      chk("t1_valid",    W'(out_valid),  W'(1));
      chk("t1_in_ready", W'(in_ready),   W'(1));
    end
    drv(1'b0, 6'h00, '0, 4'h0, 1'b1);
    step();
    chk("t1_drain_valid", W'(out_valid), W'(0));

    // Skid fill and drain
    drv(1'b1, 6'h02, W'('hA), 4'h2, 1'b0);
    step();
    chk("t2_alu_a",   alu_out,       W'('hA));
    chk("t2_rdy_one", W'(in_ready),  W'(1));
    drv(1'b1, 6'h02, W'('hB), 4'h3, 1'b0);
    step();
    chk("t2_rdy_two", W'(in_ready),  W'(0));
    chk("t2_hold_a",  alu_out,       W'('hA));
    chk("t2_valid",   W'(out_valid), W'(1));
    drv(1'b0, 6'h00, '0, 4'h0, 1'b1);
    step();
    chk("t2_alu_b",   alu_out,       W'('hB));
    chk("t2_rr_b",    W'(rr_out),    W'(3));
    chk("t2_valid_b", W'(out_valid), W'(1));
    chk("t2_rdy_back", W'(in_ready), W'(1));
    step();
    chk("t2_empty", W'(out_valid), W'(0));

    // Bubble after an all-ones control word
    drv(1'b1, 6'h3F, W'('h55), 4'h5, 1'b1);
    step();
    chk("t3_ctrl_full", W'(ctrl_out), W'('h3F));
    drv(1'b0, 6'h3F, W'('h66), 4'h6, 1'b1);
    step();
    chk("t3_ctrl_bubble",  W'(ctrl_out),  W'(0));
    chk("t3_valid_bubble", W'(out_valid), W'(0));
    chk("t3_alu_stale",    alu_out,       W'('h55));

    // Flush from TWO and from ONE
    drv(1'b1, 6'h01, W'('h11), 4'h1, 1'b0);
    step();
    drv(1'b1, 6'h01, W'('h22), 4'h2, 1'b0);
    step();
    chk("t4_rdy_two", W'(in_ready), W'(0));
    flush = 1'b1;
    drv(1'b1, 6'h01, W'('h33), 4'h3, 1'b0);
    step();
    flush = 1'b0;
    chk("t4_valid",    W'(out_valid), W'(0));
    chk("t4_ctrl",     W'(ctrl_out),  W'(0));
    chk("t4_in_ready", W'(in_ready),  W'(1));
    chk("t4_alu_stale", alu_out,      W'('h11));
    drv(1'b0, 6'h00, '0, 4'h0, 1'b1);
    step();
    chk("t4_no_ghost", W'(out_valid), W'(0));
    drv(1'b1, 6'h04, W'('h44), 4'h4, 1'b1);
    step();
    chk("t4_alu_44", alu_out, W'('h44));
    flush = 1'b1;
    drv(1'b1, 6'h04, W'('h45), 4'h5, 1'b1);
    step();
    flush = 1'b0;
    chk("t4_flush_valid", W'(out_valid), W'(0));
    chk("t4_flush_drop",  alu_out,       W'('h44));

    // Stall counter saturation
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cnt", W'(stall_cnt), W'(0));
    rst_n = 1'b1;
    drv(1'b1, 6'h01, W'('h66), 4'h6, 1'b0);
    step();
    chk("t5_load_cnt", W'(stall_cnt), W'(0));
    drv(1'b0, 6'h00, '0, 4'h0, 1'b0);
    repeat (5) step();
    chk("t5_cnt5", W'(stall_cnt), W'(5));
    repeat (15) step();
    chk("t5_cnt_sat", W'(stall_cnt), W'(15));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_cnt_flush", W'(stall_cnt), W'(15));
    chk("t5_flush_valid", W'(out_valid), W'(0));
    drv(1'b1, 6'h01, W'('h77), 4'h7, 1'b0);
    step();
    chk("t5_reload_valid", W'(out_valid), W'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_mid_in_ready", W'(in_ready),  W'(1));
    chk("t5_mid_valid",    W'(out_valid), W'(0));
    chk("t5_mid_cnt",      W'(stall_cnt), W'(0));
    chk("t5_mid_alu",      alu_out,       W'(0));
    rst_n = 1'b1;
    drv(1'b0, 6'h00, '0, 4'h0, 1'b0);

    // Single-entry variant: combinational in_ready
    drv(1'b1, 6'h02, W'('h88), 4'h9, 1'b0);
    step();
    chk("t6_rr",        W'(rr_out0),    W'(9));
    chk("t6_valid",     W'(out_valid0), W'(1));
    chk("t6_rdy_stall", W'(in_ready0),  W'(0));
    out_ready = 1'b1;
    #1;
    chk("t6_rdy_comb",  W'(in_ready0),  W'(1));
    drv(1'b1, 6'h02, W'('h99), 4'hC, 1'b1);
    step();
    chk("t6_rr_next",   W'(rr_out0),    W'('hC));
    chk("t6_alu_next",  alu_out0,       W'('h99));
    chk("t6_mux1_next", mux1_out0,      ~W'('h99));
    chk("t6_ctrl_next", W'(ctrl_out0),  W'(2));
    drv(1'b0, 6'h00, '0, 4'h0, 1'b1);
    step();
    chk("t6_empty",     W'(out_valid0), W'(0));
    chk("t6_cnt",       W'(stall_cnt0), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
